reg_file_rename: RTL and testbench

- Architectural integer register file with per-register rename tags.
- Sits directly downstream of the ROB commit port and alongside the decoder.
- Decoder reads operands and gets either a committed value or the ROB tag of the producing instruction.
- Decoder claims a destination register at issue. ROB commit retires values and clears tags. ROB flush discards all outstanding renames.

---
 rtl/reg_file_rename.sv | 130 +++++++++++++
 tb/tb_reg_file_rename.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_rename.sv
// -----------------------------------------------------------------------------
// reg_file_rename
//
// Architectural integer register file with a rename tag per register. The
// decoder reads two source operands and gets either the committed value or the
// ROB tag of the in-flight producer. The decoder claims a destination at issue.
// The ROB commit port retires values and releases tags. A ROB flush drops all
// outstanding renames.
//
// Optional feature (compile-time macro): REGFILE_COMMIT_BYPASS_EN
//   When defined, a source read forwards the commit arriving in the same cycle
//   if that commit releases the register's current tag. The read then returns
//   busy = 0 and the commit value.
//
// Ports
//   in_clk, in_rst            clock, synchronous active-high reset
//   in_rdy                    global ready; low holds all state
//   in_flush_enable           ROB flush, clears every busy bit
//   in_decoder_rs/rt          source indices
//   out_decoder_rs/rt_*       busy / producer tag / committed value
//   in_decoder_rename_*       destination claim (rd, ROB tag)
//   in_rob_commit_*           retire (rd, value, ROB tag)
//
// Interface semantics: there is no valid/ready handshake. Every *_enable input
// is a single-cycle valid pulse. It is consumed on the rising edge where in_rdy
// is high. When in_rdy is low the pulse has no effect. Nothing is ever stalled
// back toward the decoder or the ROB.
// -----------------------------------------------------------------------------
module reg_file_rename #(
    parameter int REG_NUM = 32,
    parameter int REG_W   = 5,
    parameter int DATA_W  = 32,
    parameter int ROB_W   = 4
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_rdy,
    input  logic              in_flush_enable,
    input  logic [REG_W-1:0]  in_decoder_rs,
    input  logic [REG_W-1:0]  in_decoder_rt,
    output logic              out_decoder_rs_busy,
    output logic [ROB_W-1:0]  out_decoder_rs_reorder,
    output logic [DATA_W-1:0] out_decoder_rs_value,
    output logic              out_decoder_rt_busy,
    output logic [ROB_W-1:0]  out_decoder_rt_reorder,
    output logic [DATA_W-1:0] out_decoder_rt_value,
    input  logic              in_decoder_rename_enable,
    input  logic [REG_W-1:0]  in_decoder_rd,
    input  logic [ROB_W-1:0]  in_decoder_reorder,
    input  logic              in_rob_commit_enable,
    input  logic [REG_W-1:0]  in_rob_commit_rd,
    input  logic [DATA_W-1:0] in_rob_commit_value,
    input  logic [ROB_W-1:0]  in_rob_commit_reorder
);

    logic [DATA_W-1:0] value_q [REG_NUM];
    logic              busy_q  [REG_NUM];
    logic [ROB_W-1:0]  tag_q   [REG_NUM];

    // x0 is never written after reset. Its entry stays zero, and the read path
    // masks it as well.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                value_q[i] <= '0;
                busy_q[i]  <= 1'b0;
                tag_q[i]   <= '0;
            end
        end else if (in_rdy) begin
            for (int i = 1; i < REG_NUM; i++) begin
                // The value write ignores the tag. An older commit still
                // updates the value, even while a younger rename owns rd.
                if (in_rob_commit_enable && in_rob_commit_rd == REG_W'(i))
                    value_q[i] <= in_rob_commit_value;

                if (in_flush_enable) begin
                    // Tags are left stale. They are only meaningful while busy.
                    busy_q[i] <= 1'b0;
                end else if (in_decoder_rename_enable && in_decoder_rd == REG_W'(i)) begin
                    // A same-cycle rename wins over a release of the same rd.
                    busy_q[i] <= 1'b1;
                    tag_q[i]  <= in_decoder_reorder;
                end else if (in_rob_commit_enable && in_rob_commit_rd == REG_W'(i)
                             && busy_q[i] && tag_q[i] == in_rob_commit_reorder) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    // Source read ports: combinational, pre-edge state, x0 reads as zero.
    always_comb begin
        out_decoder_rs_busy    = 1'b0;
        out_decoder_rs_reorder = '0;
        out_decoder_rs_value   = '0;
        if (in_decoder_rs != '0) begin
            out_decoder_rs_busy    = busy_q[in_decoder_rs];
            out_decoder_rs_reorder = tag_q[in_decoder_rs];
            out_decoder_rs_value   = value_q[in_decoder_rs];
`ifdef REGFILE_COMMIT_BYPASS_EN
            if (in_rob_commit_enable && in_rob_commit_rd == in_decoder_rs
                && busy_q[in_decoder_rs]
                && tag_q[in_decoder_rs] == in_rob_commit_reorder) begin
                out_decoder_rs_busy  = 1'b0;
                out_decoder_rs_value = in_rob_commit_value;
            end
`endif
        end
    end

    always_comb begin
        out_decoder_rt_busy    = 1'b0;
        out_decoder_rt_reorder = '0;
        out_decoder_rt_value   = '0;
        if (in_decoder_rt != '0) begin
            out_decoder_rt_busy    = busy_q[in_decoder_rt];
            out_decoder_rt_reorder = tag_q[in_decoder_rt];
            out_decoder_rt_value   = value_q[in_decoder_rt];
`ifdef REGFILE_COMMIT_BYPASS_EN
            if (in_rob_commit_enable && in_rob_commit_rd == in_decoder_rt
                && busy_q[in_decoder_rt]
                && tag_q[in_decoder_rt] == in_rob_commit_reorder) begin
                out_decoder_rt_busy  = 1'b0;
                out_decoder_rt_value = in_rob_commit_value;
            end
`endif
        end
    end

endmodule

// File: tb/tb_reg_file_rename.sv
module tb_reg_file_rename;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int ROB_W  = 4;
    localparam int W      = 1 + ROB_W + DATA_W;

    // ---------------- clock / reset ----------------
    logic in_clk = 1'b0;
    logic in_rst = 1'b1;
    always #5 in_clk = ~in_clk;

    logic              in_rdy;
    logic              in_flush_enable;
    logic [REG_W-1:0]  in_decoder_rs, in_decoder_rt;
    logic              out_decoder_rs_busy, out_decoder_rt_busy;
    logic [ROB_W-1:0]  out_decoder_rs_reorder, out_decoder_rt_reorder;
    logic [DATA_W-1:0] out_decoder_rs_value, out_decoder_rt_value;
    logic              in_decoder_rename_enable;
    logic [REG_W-1:0]  in_decoder_rd;
    logic [ROB_W-1:0]  in_decoder_reorder;
    logic              in_rob_commit_enable;
    logic [REG_W-1:0]  in_rob_commit_rd;
    logic [DATA_W-1:0] in_rob_commit_value;
    logic [ROB_W-1:0]  in_rob_commit_reorder;

    reg_file_rename dut (
        .in_clk                   (in_clk),
        .in_rst                   (in_rst),
        .in_rdy                   (in_rdy),
        .in_flush_enable          (in_flush_enable),
        .in_decoder_rs            (in_decoder_rs),
        .in_decoder_rt            (in_decoder_rt),
        .out_decoder_rs_busy      (out_decoder_rs_busy),
        .out_decoder_rs_reorder   (out_decoder_rs_reorder),
        .out_decoder_rs_value     (out_decoder_rs_value),
        .out_decoder_rt_busy      (out_decoder_rt_busy),
        .out_decoder_rt_reorder   (out_decoder_rt_reorder),
        .out_decoder_rt_value     (out_decoder_rt_value),
        .in_decoder_rename_enable (in_decoder_rename_enable),
        .in_decoder_rd            (in_decoder_rd),
        .in_decoder_reorder       (in_decoder_reorder),
        .in_rob_commit_enable     (in_rob_commit_enable),
        .in_rob_commit_rd         (in_rob_commit_rd),
        .in_rob_commit_value      (in_rob_commit_value),
        .in_rob_commit_reorder    (in_rob_commit_reorder)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic              rdy;
        logic              ren;
        logic [REG_W-1:0]  rd;
        logic [ROB_W-1:0]  rtag;
        logic              cen;
        logic [REG_W-1:0]  crd;
        logic [ROB_W-1:0]  ctag;
        logic [DATA_W-1:0] cval;
        logic              flush;
        logic [REG_W-1:0]  chk;
        logic              ebusy;
        logic [ROB_W-1:0]  etag;
        logic [DATA_W-1:0] eval;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rdy, logic ren, logic [REG_W-1:0] rd,
                                logic [ROB_W-1:0] rtag, logic cen,
                                logic [REG_W-1:0] crd, logic [ROB_W-1:0] ctag,
                                logic [DATA_W-1:0] cval, logic flush,
                                logic [REG_W-1:0] chk, logic ebusy,
                                logic [ROB_W-1:0] etag, logic [DATA_W-1:0] eval);
        vec_t v;
        v.rdy = rdy; v.ren = ren; v.rd = rd; v.rtag = rtag;
        v.cen = cen; v.crd = crd; v.ctag = ctag; v.cval = cval;
        v.flush = flush; v.chk = chk;
        v.ebusy = ebusy; v.etag = etag; v.eval = eval;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic expect_read(input logic b, input logic [ROB_W-1:0] t,
                               input logic [DATA_W-1:0] v);
        exp_q.push_back({b, t, v});
    endtask

    task automatic compare(input string name, input logic [W-1:0] act);
        logic [W-1:0] exp;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got busy=%0b tag=%0d value=%h, no expected entry",
                     name, act[W-1], act[W-2 -: ROB_W], act[DATA_W-1:0]);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                n_fail++;
                $display("FAIL %s: got busy=%0b tag=%0d value=%h, want busy=%0b tag=%0d value=%h",
                         name, act[W-1], act[W-2 -: ROB_W], act[DATA_W-1:0],
                         exp[W-1], exp[W-2 -: ROB_W], exp[DATA_W-1:0]);
            end
        end
    endtask

    task automatic check_rs(input string name);
        compare(name, {out_decoder_rs_busy, out_decoder_rs_reorder, out_decoder_rs_value});
    endtask

    task automatic check_rt(input string name);
        compare(name, {out_decoder_rt_busy, out_decoder_rt_reorder, out_decoder_rt_value});
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        in_rdy                   = 1'b1;
        in_flush_enable          = 1'b0;
        in_decoder_rename_enable = 1'b0;
        in_decoder_rd            = '0;
        in_decoder_reorder       = '0;
        in_rob_commit_enable     = 1'b0;
        in_rob_commit_rd         = '0;
        in_rob_commit_value      = '0;
        in_rob_commit_reorder    = '0;
    endtask

    task automatic drive_cycle(input vec_t v);
        @(negedge in_clk);
        in_rdy                   = v.rdy;
        in_decoder_rename_enable = v.ren;
        in_decoder_rd            = v.rd;
        in_decoder_reorder       = v.rtag;
        in_rob_commit_enable     = v.cen;
        in_rob_commit_rd         = v.crd;
        in_rob_commit_reorder    = v.ctag;
        in_rob_commit_value      = v.cval;
        in_flush_enable          = v.flush;
        @(posedge in_clk);
        #1;
        idle_inputs();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        in_decoder_rs = '0;
        in_decoder_rt = '0;

        // Reset for two edges, then release.
        repeat (2) @(posedge in_clk);
        #1 in_rst = 1'b0;

        // Reset state on both ports.
        in_decoder_rs = 5'd5; in_decoder_rt = 5'd0; #1;
        expect_read(1'b0, 4'd0, 32'h0); check_rs("reset_rs_x5");
        expect_read(1'b0, 4'd0, 32'h0); check_rt("reset_rt_x0");
        in_decoder_rs = 5'd0; in_decoder_rt = 5'd5; #1;
        expect_read(1'b0, 4'd0, 32'h0); check_rs("reset_rs_x0");
        expect_read(1'b0, 4'd0, 32'h0); check_rt("reset_rt_x5");

        // Fields: rdy ren rd rtag | cen crd ctag cval | flush | chk -> busy tag value
        vecs.push_back(mk(1, 1, 5,  3, 0, 0,  0, 32'h0,        0, 5,  1, 3, 32'h0));
        vecs.push_back(mk(1, 0, 0,  0, 1, 5,  3, 32'hDEADBEEF, 0, 5,  0, 3, 32'hDEADBEEF));
        vecs.push_back(mk(1, 1, 7,  2, 0, 0,  0, 32'h0,        0, 7,  1, 2, 32'h0));
        vecs.push_back(mk(1, 1, 7,  4, 0, 0,  0, 32'h0,        0, 7,  1, 4, 32'h0));
        vecs.push_back(mk(1, 0, 0,  0, 1, 7,  2, 32'h11,       0, 7,  1, 4, 32'h11));
        vecs.push_back(mk(1, 0, 0,  0, 1, 7,  4, 32'h22,       0, 7,  0, 4, 32'h22));
        vecs.push_back(mk(1, 1, 9,  6, 1, 9,  1, 32'h55,       0, 9,  1, 6, 32'h55));
        vecs.push_back(mk(1, 1, 3,  2, 0, 0,  0, 32'h0,        0, 3,  1, 2, 32'h0));
        vecs.push_back(mk(1, 1, 4,  5, 0, 0,  0, 32'h0,        0, 4,  1, 5, 32'h0));
        vecs.push_back(mk(1, 1, 6,  7, 1, 1,  0, 32'h80000004, 1, 1,  0, 0, 32'h80000004));
        vecs.push_back(mk(1, 0, 0,  0, 0, 0,  0, 32'h0,        0, 3,  0, 2, 32'h0));
        vecs.push_back(mk(1, 0, 0,  0, 0, 0,  0, 32'h0,        0, 4,  0, 5, 32'h0));
        vecs.push_back(mk(1, 0, 0,  0, 0, 0,  0, 32'h0,        0, 6,  0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0,  0, 0, 0,  0, 32'h0,        0, 9,  0, 6, 32'h55));
        vecs.push_back(mk(1, 1, 0,  3, 0, 0,  0, 32'h0,        0, 0,  0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0,  0, 1, 0,  3, 32'h1234,     0, 0,  0, 0, 32'h0));
        vecs.push_back(mk(1, 1, 10, 1, 1, 5,  9, 32'h77,       0, 10, 1, 1, 32'h0));
        vecs.push_back(mk(1, 0, 0,  0, 0, 0,  0, 32'h0,        0, 5,  0, 3, 32'h77));
        vecs.push_back(mk(0, 1, 11, 2, 1, 11, 2, 32'h99,       1, 11, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0,  0, 1, 10, 1, 32'hAA,       1, 10, 1, 1, 32'h0));
        vecs.push_back(mk(1, 0, 0,  0, 1, 9,  6, 32'h66,       0, 9,  0, 6, 32'h66));

        foreach (vecs[k]) begin
            drive_cycle(vecs[k]);
            in_decoder_rs = vecs[k].chk;
            #1;
            expect_read(vecs[k].ebusy, vecs[k].etag, vecs[k].eval);
            check_rs($sformatf("vec%0d_x%0d", k, vecs[k].chk));
        end

        // Both read ports at once, combinational and with no edge in between.
        in_decoder_rs = 5'd7; in_decoder_rt = 5'd10; #1;
        expect_read(1'b0, 4'd4, 32'h22); check_rs("dual_rs_x7");
        expect_read(1'b1, 4'd1, 32'h0);  check_rt("dual_rt_x10");

        // Same-cycle commit into a busy register with its matching tag.
        // The registered result is checked afterwards; the bypass is checked here.
        @(negedge in_clk);
        in_decoder_rename_enable = 1'b1; in_decoder_rd = 5'd12; in_decoder_reorder = 4'd3;
        @(posedge in_clk); #1; idle_inputs();
        @(negedge in_clk);
        in_decoder_rs = 5'd12; in_decoder_rt = 5'd12;
        in_rob_commit_enable = 1'b1; in_rob_commit_rd = 5'd12;
        in_rob_commit_reorder = 4'd2; in_rob_commit_value = 32'hAB;
        #1;
        // Tag mismatch: never forwarded.
        expect_read(1'b1, 4'd3, 32'h0); check_rs("bypass_tag_mismatch");
        in_rob_commit_reorder = 4'd3; #1;
`ifdef REGFILE_COMMIT_BYPASS_EN
        expect_read(1'b0, 4'd3, 32'hAB); check_rs("bypass_rs_x12");
        expect_read(1'b0, 4'd3, 32'hAB); check_rt("bypass_rt_x12");
`else
        expect_read(1'b1, 4'd3, 32'h0);  check_rs("no_bypass_rs_x12");
        expect_read(1'b1, 4'd3, 32'h0);  check_rt("no_bypass_rt_x12");
`endif
        @(posedge in_clk); #1; idle_inputs(); #1;
        expect_read(1'b0, 4'd3, 32'hAB); check_rs("commit_x12_after_edge");

        // Reset dominates a same-cycle rename and commit.
        @(negedge in_clk);
        in_rst = 1'b1;
        in_decoder_rename_enable = 1'b1; in_decoder_rd = 5'd10; in_decoder_reorder = 4'd8;
        in_rob_commit_enable = 1'b1; in_rob_commit_rd = 5'd7; in_rob_commit_value = 32'h5A;
        @(posedge in_clk); #1;
        in_rst = 1'b0; idle_inputs();
        in_decoder_rs = 5'd10; in_decoder_rt = 5'd7; #1;
        expect_read(1'b0, 4'd0, 32'h0); check_rs("rst_clears_x10");
        expect_read(1'b0, 4'd0, 32'h0); check_rt("rst_clears_x7");

        // ---------------- final report ----------------
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion by 100000, want completion");
        $fatal(1, "timeout");
    end

endmodule
